// File: rtl/fe_cmp_seq_if.sv
// Request/result handshake bundle for the sequential field-element comparator.
interface fe_cmp_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [319:0] f_a;
  logic [319:0] f_b;
  logic         out_valid;
  logic         out_ready;
  logic         result;
  logic         busy;

  modport master (
    output in_valid, mode, f_a, f_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, mode, f_a, f_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/fe_cmp_seq.sv
// Constant-time GF(2^255-19) comparator: canonicalises both operands, then
// XOR/OR-scans them CHUNK_W bits per cycle (isnonzero / neq / eq / isnegative).
module fe_cmp_seq #(
  parameter int unsigned CHUNK_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fe_cmp_seq_if.slave  bus
);
  localparam int unsigned NCHUNK = 256 / CHUNK_W;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (!(CHUNK_W == 8 || CHUNK_W == 16 || CHUNK_W == 32 ||
          CHUNK_W == 64 || CHUNK_W == 128 || CHUNK_W == 256)) begin : g_bad_chunk
      $error("fe_cmp_seq: CHUNK_W must be one of 8,16,32,64,128,256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t             state, state_nxt;
  logic [319:0]       ra, rb;
  logic [1:0]         rmode;
  logic [255:0]       sa, sb;
  logic [255:0]       enc_a, enc_b;
  logic               acc, neg;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  // ref10 fe_tobytes: estimate the quotient by p, fold it back with 19*q,
  // then ripple carries so every limb lands in its nominal 26/25-bit range.
  function automatic logic [255:0] fe_tobytes(input logic [319:0] f);
    logic signed [63:0] h [10];
    logic signed [63:0] q, c;
    logic [255:0]       o;
    int unsigned        w;
    for (int unsigned i = 0; i < 10; i++)
      h[i] = 64'(signed'(f[32*i +: 32]));
    q = (64'sd19 * h[9] + (64'sd1 <<< 24)) >>> 25;
    for (int unsigned i = 0; i < 10; i++) begin
      w = (i % 2 == 0) ? 26 : 25;
      q = (h[i] + q) >>> w;
    end
    h[0] = h[0] + 64'sd19 * q;
    for (int unsigned i = 0; i < 9; i++) begin
      w = (i % 2 == 0) ? 26 : 25;
      c = h[i] >>> w;
      h[i+1] = h[i+1] + c;
      h[i] = h[i] - (c <<< w);
    end
    c = h[9] >>> 25;
    h[9] = h[9] - (c <<< 25);
    o = '0;
    for (int unsigned i = 0; i < 10; i++)
      o = o | (256'(h[i][25:0]) << ((51 * i + 1) / 2));
    return o;
  endfunction

  assign enc_a = fe_tobytes(ra);
  assign enc_b = fe_tobytes(rb);
  assign last  = (cnt == CNT_W'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)  state_nxt = LOAD;
      LOAD:                    state_nxt = SCAN;
      SCAN: if (last)          state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == LOAD) || (state == SCAN);
    bus.out_valid = (state == DONE);
    bus.result    = 1'b0;
    if (state == DONE) begin
      case (rmode)
        2'b00, 2'b01: bus.result = acc;
        2'b10:        bus.result = ~acc;
        default:      bus.result = neg;
      endcase
    end
  end

  // Datapath: identical sequence of shifts and counter steps for every operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      rmode <= '0;
      sa    <= '0;
      sb    <= '0;
      acc   <= 1'b0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra    <= bus.f_a;
            rb    <= bus.f_b;
            rmode <= bus.mode;
          end
        end
        LOAD: begin
          sa  <= enc_a;
          sb  <= (rmode == 2'b00 || rmode == 2'b11) ? '0 : enc_b;
          neg <= enc_a[0];
          acc <= 1'b0;
          cnt <= '0;
        end
        SCAN: begin
          acc <= acc | (|(sa[CHUNK_W-1:0] ^ sb[CHUNK_W-1:0]));
          sa  <= sa >> CHUNK_W;
          sb  <= sb >> CHUNK_W;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fe_cmp_seq.sv
// Randomised self-checking bench for fe_cmp_seq against a big-integer mod-p model.
module tb_fe_cmp_seq;
  parameter int unsigned CHUNK_W = 32;
  localparam int unsigned NCHUNK = 256 / CHUNK_W;
  localparam int unsigned LAT    = NCHUNK + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fe_cmp_seq_if bus ();

  fe_cmp_seq #(.CHUNK_W(CHUNK_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [287:0] P288 = (288'd1 << 255) - 288'd19;

  // Field value = sum limb_i * 2^ceil(25.5*i), reduced mod p.
  function automatic logic [255:0] canon(input logic [319:0] f);
    logic [287:0] v;
    v = '0;
    for (int i = 0; i < 10; i++)
      v = v + (288'(f[32*i +: 32]) << ((51 * i + 1) / 2));
    return 256'(v % P288);
  endfunction

  function automatic bit model(input bit [1:0] m, input logic [319:0] a, input logic [319:0] b);
    logic [255:0] ca, cb;
    ca = canon(a);
    cb = canon(b);
    case (m)
      2'b00:   return ca != '0;
      2'b01:   return ca != cb;
      2'b10:   return ca == cb;
      default: return ca[0];
    endcase
  endfunction

  function automatic logic [319:0] mk(input logic [31:0] l0);
    logic [319:0] f;
    f = '0;
    f[31:0] = l0;
    return f;
  endfunction

  function automatic logic [319:0] pfe(input logic [31:0] l0);
    logic [319:0] f;
    f[31:0] = l0;
    for (int i = 1; i < 10; i++)
      f[32*i +: 32] = (i % 2 == 1) ? 32'h01FF_FFFF : 32'h03FF_FFFF;
    return f;
  endfunction

  function automatic logic [319:0] rand_fe();
    logic [319:0] f;
    for (int i = 0; i < 10; i++)
      f[32*i +: 32] = $urandom & ((i % 2 == 0) ? 32'h03FF_FFFF : 32'h01FF_FFFF);
    return f;
  endfunction

  // Drive one request; returns result, latency in cycles from the accept cycle,
  // busy seen in the cycle after accept, and post-consume out_valid/in_ready.
  task automatic do_op(input bit [1:0] m, input logic [319:0] a, input logic [319:0] b,
                       input bit consume, output bit res, output int lat, output bit ok,
                       output bit busy_ld, output bit ov_after, output bit ir_after);
    int n;
    bit acc_ok;
    ok = 1'b0; res = 1'b0; lat = 0; busy_ld = 1'b0; ov_after = 1'b1; ir_after = 1'b0;
    @(negedge clk);
    bus.out_ready = consume;
    bus.mode = m; bus.f_a = a; bus.f_b = b; bus.in_valid = 1'b1;
    acc_ok = 1'b0;
    for (int i = 0; i < 50 && !acc_ok; i++) begin
      if (bus.in_ready) acc_ok = 1'b1;
      @(posedge clk);
      if (!acc_ok) @(negedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.mode = 2'($urandom); bus.f_a = rand_fe(); bus.f_b = rand_fe();
    busy_ld = bus.busy;
    if (!acc_ok) return;
    n = 0;
    while (n < 600) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) return;
    ok = 1'b1;
    lat = n + 1;
    res = bus.result;
    if (consume) begin
      @(posedge clk); #1;
      ov_after = bus.out_valid;
      ir_after = bus.in_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mode = '0; bus.f_a = '0; bus.f_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.result !== 1'b0) begin bad++; $display("FAIL reset_result got=%b want=0", bus.result); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_directed();
    bit [1:0]     m [8];
    logic [319:0] a [8];
    logic [319:0] b [8];
    bit           e [8];
    bit res, ok, bl, ova, ira;
    int lat;
    m[0]=2'b00; a[0]='0;                 b[0]=rand_fe();            e[0]=1'b0;
    m[1]=2'b00; a[1]=mk(1);              b[1]=rand_fe();            e[1]=1'b1;
    m[2]=2'b00; a[2]=pfe(32'h03FF_FFED); b[2]=mk(5);                e[2]=1'b0;
    m[3]=2'b01; a[3]=mk(1);              b[3]=pfe(32'h03FF_FFEE);   e[3]=1'b0;
    m[4]=2'b10; a[4]=mk(1);              b[4]=pfe(32'h03FF_FFEE);   e[4]=1'b1;
    m[5]=2'b01; a[5]=mk(1);              b[5]=mk(2);                e[5]=1'b1;
    m[6]=2'b11; a[6]=mk(1);              b[6]=rand_fe();            e[6]=1'b1;
    m[7]=2'b11; a[7]=mk(2);              b[7]=mk(1);                e[7]=1'b0;
    for (int i = 0; i < 8; i++) begin
      do_op(m[i], a[i], b[i], 1'b1, res, lat, ok, bl, ova, ira);
      total++; if (!ok) begin bad++; $display("FAIL dir%0d_timeout got=no_out_valid want=out_valid", i); end
      total++; if (res !== e[i]) begin bad++; $display("FAIL dir%0d_result mode=%0d got=%b want=%b", i, m[i], res, e[i]); end
      total++; if (lat != LAT) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT); end
      total++; if (bl !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%b want=1", i, bl); end
      total++; if (ova !== 1'b0 || ira !== 1'b1) begin bad++; $display("FAIL dir%0d_release got=ov%b/ir%b want=ov0/ir1", i, ova, ira); end
    end
  endtask

  task automatic test_random();
    bit [1:0] m;
    logic [319:0] a, b;
    bit res, ok, bl, ova, ira, e;
    int lat, k, sel;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom);
      sel = $urandom_range(0, 5);
      k = $urandom_range(0, 18);
      a = (sel == 1 || sel == 2) ? pfe(32'h03FF_FFED + 32'(k)) : rand_fe();
      case (sel)
        0:       b = a;
        1:       b = mk(32'(k));
        2:       b = mk(32'(k ^ 1));
        default: b = rand_fe();
      endcase
      e = model(m, a, b);
      do_op(m, a, b, 1'b1, res, lat, ok, bl, ova, ira);
      total++; if (!ok || res !== e) begin bad++; $display("FAIL rnd%0d_result mode=%0d ok=%b got=%b want=%b", i, m, ok, res, e); end
      total++; if (lat != LAT) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, LAT); end
    end
  endtask

  task automatic test_backpressure();
    bit res, ok, bl, ova, ira;
    int lat;
    do_op(2'b10, pfe(32'h03FF_FFF0), mk(3), 1'b0, res, lat, ok, bl, ova, ira);
    total++; if (!ok || res !== 1'b1) begin bad++; $display("FAIL bp_result ok=%b got=%b want=1", ok, res); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.mode = 2'($urandom); bus.f_a = rand_fe(); bus.f_b = rand_fe();
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || bus.result !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=ov%b/res%b want=ov1/res1", i, bus.out_valid, bus.result); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b want=0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=ov%b/ir%b want=ov0/ir1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept got=busy%b want=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit res, ok, bl, ova, ira;
    int lat, k, highs;
    k = (NCHUNK >= 4) ? 4 : NCHUNK;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.mode = 2'b00; bus.f_a = mk(7); bus.f_b = '0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 1'b0) begin bad++; $display("FAIL mid_cleared got=ov%b/busy%b/res%b want=0/0/0", bus.out_valid, bus.busy, bus.result); end
    @(negedge clk); rst_n = 1'b1;
    highs = 0;
    repeat (NCHUNK + 5) begin
      @(posedge clk); #1;
      if (bus.out_valid) highs++;
    end
    total++; if (highs != 0) begin bad++; $display("FAIL mid_no_pulse got=%0d want=0", highs); end
    do_op(2'b01, mk(9), mk(9), 1'b1, res, lat, ok, bl, ova, ira);
    total++; if (!ok || res !== 1'b0) begin bad++; $display("FAIL mid_after_result ok=%b got=%b want=0", ok, res); end
    total++; if (lat != LAT) begin bad++; $display("FAIL mid_after_latency got=%0d want=%0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fe_cmp_seq.md
Name: fe_cmp_seq

Overview:
- Sequential, constant-time comparator for GF(2^255-19) field elements in 10-limb radix-2^25.5 form.
- Generalises the single-mode combinational zero test into a handshaked unit with four modes:
  - isnonzero
  - not-equal
  - equal
  - isnegative
- Scan width per cycle is configurable, so area can be traded against latency.
- Sits beside the field-arithmetic core and feeds point-decompression and signature-verify control, which need the flags without a 256-bit-wide OR tree in one cycle.

Parameters:
- CHUNK_W, 32: canonical bits compared per scan cycle. Legal values are 8, 16, 32, 64, 128, 256; any other value fails elaboration.
- NCHUNK, 256/CHUNK_W: derived, not overridable. Number of scan cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- mode  in  2  operation select:
  - 00 isnonzero(a)
  - 01 neq(a,b)
  - 10 eq(a,b)
  - 11 isnegative(a)
- f_a  in  320  operand A, 10 x 32-bit signed limbs; limb i at [32i+31:32i]
- f_b  in  320  operand B, same format; ignored in modes 00 and 11
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  1  flag for the captured mode
- busy  out  1  high in LOAD or SCAN

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n low asynchronously forces:
  - state=IDLE
  - in_ready=1 once released
  - out_valid=0, result=0, busy=0
  - all operand, shift and accumulator registers cleared
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register f_a, f_b and mode, then go to LOAD.
  - Input is sampled only on the handshake cycle.
- LOAD (1 cycle):
  - Pass the registered operands through fe_tobytes, one instance per operand, to get canonical 32-byte encodings.
  - Bytes are packed little-endian: byte k at [8k+7:8k].
  - Load into 256-bit shift registers SA and SB.
  - In modes 00 and 11, SB is loaded with zero.
  - Latch neg = SA[0] for mode 11.
  - Clear acc; clear chunk counter.
- SCAN (NCHUNK cycles):
  - Each cycle: acc <= acc | (|(SA[CHUNK_W-1:0] ^ SB[CHUNK_W-1:0])); SA and SB shift right by CHUNK_W; counter increments.
  - Leave SCAN when counter reaches NCHUNK-1; go to DONE.
  - The scan runs in full in every mode, including mode 11. There is no early exit.
- DONE:
  - out_valid=1 and result is driven from the captured mode:
    - 00: acc
    - 01: acc
    - 10: ~acc
    - 11: neg
  - result and out_valid stay stable until out_ready=1.
  - On the out_valid&out_ready cycle, go to IDLE. out_valid drops the next cycle.
- Latency:
  - Accept at cycle T gives out_valid at T+NCHUNK+2. With CHUNK_W=32 that is T+10.
  - Latency is independent of operand values and mode (constant-time requirement).
- Throughput: one request in flight. in_ready=0 in LOAD, SCAN and DONE. No accept in the same cycle as result handshake; the next accept is possible the cycle after returning to IDLE.
- Non-canonical inputs:
  - Limbs outside nominal range are handled only as far as fe_tobytes handles them.
  - Values ≥ p compare by canonical residue, e.g. p itself reads as zero.
- Reset mid-operation: the in-flight request is discarded with no out_valid pulse, and the unit returns to IDLE.
- out_ready while out_valid=0 is ignored. Changes on f_a, f_b and mode outside the handshake cycle have no effect.
- Timing discipline: no data-dependent control paths. The state and counter sequence must be identical for all operand values.

Test Plan:
- Reset, then mode=00 with f_a all limbs 0 → result=0, out_valid exactly 10 cycles after accept (CHUNK_W=32).
- mode=00 with f_a limb0=1, other limbs 0 → result=1. Repeat with f_a = p (limb0=0x3FFFFED, odd limbs 0x1FFFFFF, even limbs 1..8 0x3FFFFFF) → result=0.
- mode=01 with a=1, b=p+1 (limb0=0x3FFFFEE, rest as p) → result=0. The same pair in mode=10 → result=1. mode=01 with a=1, b=2 → result=1.
- mode=11 with a=1 → result=1; with a=2 → result=0. Latency is identical to mode 00 (10 cycles).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: result stable, in_ready=0 and in_valid ignored throughout. Then out_ready=1 → out_valid low next cycle, in_ready high.
- Assert rst_n low at SCAN cycle 4 → outputs cleared immediately. After release there is no out_valid; a new request completes with correct result and latency. Rerun the suite at CHUNK_W=8 (latency 34) and CHUNK_W=256 (latency 3).
